pixel_sink: RTL and testbench
=============================

Name: pixel_sink

Overview:
- Consuming end of the pixel-plot interface that game objects (player, bullet, eraser) drive.
- Accepts (x, y, colour) plot requests over a valid/ready handshake and buffers them in a small FIFO.
- Bounds-checks each request, converts it to a linear framebuffer address, and issues one memory write per pixel to the framebuffer write port.
- Multiple producers can therefore plot without dropping pixels when the framebuffer port stalls.

Parameters:
- H_RES, 160, horizontal resolution in pixels; x must be < H_RES.
- V_RES, 120, vertical resolution in pixels; y must be < V_RES.
- X_W, 8, width of x coordinate.
- Y_W, 7, width of y coordinate.
- COLOUR_W, 3, colour width (1 bit per channel).
- ADDR_W, 15, framebuffer address width; must hold H_RES*V_RES-1.
- DEPTH, 8, FIFO entries; power of two, minimum 2.

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- resetn  in  1  synchronous active-low reset
- in_valid  in  1  plot request present
- in_ready  out  1  sink can accept a request this cycle
- in_x  in  X_W  pixel column
- in_y  in  Y_W  pixel row
- in_colour  in  COLOUR_W  pixel colour
- mem_addr  out  ADDR_W  framebuffer write address
- mem_data  out  COLOUR_W  framebuffer write data
- mem_wren  out  1  write request
- mem_ready  in  1  framebuffer accepts the write this cycle
- busy  out  1  FIFO non-empty or write in progress
- dropped_count  out  8  out-of-range request count (see Optional Feature)

Behaviour:
- One clock (clock); reset is synchronous, active-low (resetn). All state updates on posedge clock only.
- Reset values:
  - in_ready=0 while resetn=0, 1 on the first cycle after release.
  - mem_wren=0, mem_addr=0, mem_data=0, busy=0, dropped_count=0.
  - FIFO empty, FSM in IDLE.
- Input handshake:
  - Transfer occurs on a cycle with in_valid & in_ready.
  - in_ready = !fifo_full, registered-state based, with no combinational path from in_valid.
  - No pass-through: when full, a pop in the same cycle does not allow a push; in_ready reasserts the cycle after the pop.
- Bounds check at input:
  - Requests with in_x >= H_RES or in_y >= V_RES are consumed (handshake completes) but not stored.
  - Out-of-range requests still require in_ready=1.
- FIFO: DEPTH entries of {x, y, colour}; pointers wrap modulo DEPTH; count tracks 0..DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into work registers and go to CALC; else stay.
  - CALC: mem_addr <= y*H_RES + x (ADDR_W bits, no truncation for legal inputs); mem_data <= colour; go to WRITE.
  - WRITE: mem_wren=1; mem_addr and mem_data are held stable until mem_wren & mem_ready. On completion, if FIFO non-empty, pop the next entry and go to CALC; else go to IDLE.
- Timing:
  - Latency: a request accepted in cycle N gives mem_wren=1 in cycle N+3 if the FIFO was empty and the FSM idle.
  - Throughput: one pixel per 2 cycles with mem_ready held 1.
- mem_wren deasserts the cycle after the completing handshake unless the FSM returns directly to WRITE (it does not: CALC always intervenes).
- Capacity: with mem_ready=0, one entry sits in WRITE, so DEPTH+1 requests are accepted before in_ready falls.
- busy = (count != 0) | (state != IDLE).
- Reset mid-operation: any pending FIFO entries and the in-flight write are discarded; mem_wren=0 the cycle after resetn sampled low.
- Ordering: pixels are written strictly in acceptance order; a later write to the same address overwrites an earlier one.

Optional Feature:
- Macro PIXEL_SINK_DROP_CNT_EN.
- Defined: dropped_count increments by 1 on each consumed out-of-range request, saturates at 255, and clears only on reset.
- Undefined: no counter logic is present; dropped_count is tied to 0.
- Port list is identical in both builds.

Test Plan:
- Reset then single plot x=5, y=2, colour=3'b011, mem_ready=1 -> mem_wren high 3 cycles after accept, mem_addr=325, mem_data=3'b011, one cycle only; busy low afterwards.
- Corner plot x=159, y=119, colour=3'b111 -> mem_addr=19199; x=0, y=0 -> mem_addr=0.
- mem_ready held 0, in_valid held 1 with 12 distinct pixels -> exactly 9 accepted, then in_ready=0. Release mem_ready -> 9 writes in order at one per 2 cycles; in_ready returns the cycle after the first pop.
- Out-of-range x=160, y=10, then x=3, y=120, then legal x=1, y=1 -> only one write (addr 161). With PIXEL_SINK_DROP_CNT_EN: dropped_count=2. Without it: dropped_count=0. Then 300 out-of-range requests -> dropped_count=255 (with macro).
- mem_ready toggled 0/1 every cycle during a 4-pixel burst -> mem_addr and mem_data are stable while mem_wren=1 and mem_ready=0; 4 writes total, in order.
- resetn pulsed low for 1 cycle while 5 entries are pending and a write is stalled -> mem_wren=0, busy=0, and no further writes after reset release.

Source files
------------

// File: rtl/pixel_sink.sv
// rtl/pixel_sink.sv - pixel plot sink: input FIFO, bounds check, framebuffer writer (optional PIXEL_SINK_DROP_CNT_EN)
module pixel_sink #(
    parameter int H_RES    = 160,
    parameter int V_RES    = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int ADDR_W   = 15,
    parameter int DEPTH    = 8
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [X_W-1:0]      in_x,
    input  logic [Y_W-1:0]      in_y,
    input  logic [COLOUR_W-1:0] in_colour,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [COLOUR_W-1:0] mem_data,
    output logic                mem_wren,
    input  logic                mem_ready,
    output logic                busy,
    output logic [7:0]          dropped_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = X_W + Y_W + COLOUR_W;

    typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

    state_t               state, state_next;
    logic [ENTRY_W-1:0]   fifo_mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       count, count_next;
    logic                 ready_q;
    logic [X_W-1:0]       work_x;
    logic [Y_W-1:0]       work_y;
    logic [COLOUR_W-1:0]  work_colour;
    logic                 in_range, push, store, pop;

    assign in_range = (32'(in_x) < H_RES) && (32'(in_y) < V_RES);
    assign push     = in_valid & ready_q;
    assign store    = push & in_range;
    assign in_ready = ready_q;
    assign mem_wren = (state == WRITE);
    assign busy     = (count != '0) | (state != IDLE);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: state_next = WRITE;
            WRITE: begin
                if (mem_ready) begin
                    if (count != '0) begin
                        pop        = 1'b1;
                        state_next = CALC;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        count_next = count + (PTR_W+1)'(store) - (PTR_W+1)'(pop);
    end

    // Ready derives from next occupancy, so a pop while full only reopens the input a cycle later.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            ready_q <= (count_next != (PTR_W+1)'(DEPTH));
            if (store) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (store) fifo_mem[wr_ptr] <= {in_x, in_y, in_colour};
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            work_x      <= '0;
            work_y      <= '0;
            work_colour <= '0;
            mem_addr    <= '0;
            mem_data    <= '0;
        end else begin
            if (pop) {work_x, work_y, work_colour} <= fifo_mem[rd_ptr];
            if (state == CALC) begin
                mem_addr <= ADDR_W'(work_y) * ADDR_W'(H_RES) + ADDR_W'(work_x);
                mem_data <= work_colour;
            end
        end
    end

`ifdef PIXEL_SINK_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            drop_q <= 8'd0;
        end else if (push && !in_range && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign dropped_count = drop_q;
`else
    assign dropped_count = 8'd0;
`endif

endmodule

// File: tb/tb_pixel_sink.sv
// tb/tb_pixel_sink.sv - directed vector bench for pixel_sink
module tb_pixel_sink;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_x = '0;
    logic [6:0]  in_y = '0;
    logic [2:0]  in_colour = '0;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_wren;
    logic        mem_ready = 1'b0;
    logic        busy;
    logic [7:0]  dropped_count;

    pixel_sink dut (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_ready(mem_ready), .busy(busy), .dropped_count(dropped_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int x;
        int y;
        int c;
        int addr;
        int wr;
    } vec_t;

    vec_t vecs[7];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   exp_drop = 0;
    int   wq_addr[$];
    int   wq_data[$];
    int   wq_cyc[$];
    logic stalled = 1'b0;
    logic [14:0] hold_addr;
    logic [2:0]  hold_data;

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic note_drop(input int n);
`ifdef PIXEL_SINK_DROP_CNT_EN
        exp_drop = (exp_drop + n > 255) ? 255 : exp_drop + n;
`endif
    endtask

    // Records completed writes and checks address/data hold steady through a stall.
    always begin
        @(negedge clock);
        cyc++;
        #2;
        if (resetn && stalled && mem_wren) begin
            check("stall_addr", int'(mem_addr), int'(hold_addr));
            check("stall_data", int'(mem_data), int'(hold_data));
        end
        stalled   = resetn && mem_wren && !mem_ready;
        hold_addr = mem_addr;
        hold_data = mem_data;
        if (resetn && mem_wren && mem_ready) begin
            wq_addr.push_back(int'(mem_addr));
            wq_data.push_back(int'(mem_data));
            wq_cyc.push_back(cyc);
        end
    end

    task automatic send(input int x, input int y, input int c);
        int n = 0;
        in_x = 8'(x); in_y = 7'(y); in_colour = 3'(c); in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n == 50) check("send_timeout", n, 0);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic clear_q();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    initial begin
        int i;
        vecs[0] = '{159, 119, 7, 19199, 1};
        vecs[1] = '{0,   0,   2, 0,     1};
        vecs[2] = '{160, 10,  1, 0,     0};
        vecs[3] = '{3,   120, 2, 0,     0};
        vecs[4] = '{1,   1,   5, 161,   1};
        vecs[5] = '{10,  50,  4, 8010,  1};
        vecs[6] = '{255, 127, 6, 0,     0};

        repeat (2) @(negedge clock);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_wren", int'(mem_wren), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_data", int'(mem_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_drop", int'(dropped_count), 0);
        resetn = 1'b1;
        @(negedge clock);
        check("rel_in_ready", int'(in_ready), 1);

        mem_ready = 1'b1;
        clear_q();
        send(5, 2, 3);
        check("lat_n1_wren", int'(mem_wren), 0);
        @(negedge clock);
        check("lat_n2_wren", int'(mem_wren), 0);
        @(negedge clock);
        check("lat_n3_wren", int'(mem_wren), 1);
        check("lat_addr", int'(mem_addr), 325);
        check("lat_data", int'(mem_data), 3);
        @(negedge clock);
        check("lat_n4_wren", int'(mem_wren), 0);
        check("lat_busy", int'(busy), 0);
        check("lat_writes", wq_addr.size(), 1);

        for (int v = 0; v < 7; v++) begin
            clear_q();
            send(vecs[v].x, vecs[v].y, vecs[v].c);
            if (vecs[v].wr == 0) note_drop(1);
            repeat (6) @(negedge clock);
            check($sformatf("vec%0d_count", v), wq_addr.size(), vecs[v].wr);
            if (wq_addr.size() == 1 && vecs[v].wr == 1) begin
                check($sformatf("vec%0d_addr", v), wq_addr[0], vecs[v].addr);
                check($sformatf("vec%0d_data", v), wq_data[0], vecs[v].c);
            end
        end
        check("drop_after_table", int'(dropped_count), exp_drop);

        in_x = 8'd200; in_y = 7'd0; in_valid = 1'b1;
        repeat (300) @(negedge clock);
        in_valid = 1'b0;
        note_drop(300);
        @(negedge clock);
        check("drop_saturate", int'(dropped_count), exp_drop);

        // Capacity: one entry parks in WRITE, DEPTH more fill the FIFO.
        mem_ready = 1'b0;
        i = 0;
        for (int k = 0; k < 20; k++) begin
            in_valid = (i < 12); in_x = 8'(i + 10); in_y = 7'(i + 20); in_colour = 3'(i);
            if (in_valid && in_ready) i++;
            @(negedge clock);
        end
        in_valid = 1'b0;
        check("cap_accepted", i, 9);
        check("cap_in_ready", int'(in_ready), 0);
        clear_q();
        mem_ready = 1'b1;
        @(negedge clock);
        check("cap_ready_back", int'(in_ready), 1);
        repeat (25) @(negedge clock);
        check("cap_writes", wq_addr.size(), 9);
        if (wq_addr.size() == 9) begin
            for (int k = 0; k < 9; k++) begin
                check($sformatf("cap_addr%0d", k), wq_addr[k], (k + 20) * 160 + k + 10);
                check($sformatf("cap_data%0d", k), wq_data[k], k % 8);
                if (k > 0) check($sformatf("cap_gap%0d", k), wq_cyc[k] - wq_cyc[k-1], 2);
            end
        end

        clear_q();
        i = 0;
        for (int k = 0; k < 40; k++) begin
            mem_ready = k[0];
            in_valid = (i < 4); in_x = 8'(i * 7 + 1); in_y = 7'(i * 3 + 2); in_colour = 3'(i + 4);
            if (in_valid && in_ready) i++;
            @(negedge clock);
        end
        in_valid = 1'b0;
        mem_ready = 1'b1;
        repeat (5) @(negedge clock);
        check("tog_writes", wq_addr.size(), 4);
        if (wq_addr.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("tog_addr%0d", k), wq_addr[k], (k * 3 + 2) * 160 + k * 7 + 1);
                check($sformatf("tog_data%0d", k), wq_data[k], (k + 4) % 8);
            end
        end

        mem_ready = 1'b0;
        i = 0;
        for (int k = 0; k < 10; k++) begin
            in_valid = (i < 6); in_x = 8'(i + 30); in_y = 7'(i + 40); in_colour = 3'(i);
            if (in_valid && in_ready) i++;
            @(negedge clock);
        end
        in_valid = 1'b0;
        check("mid_pending", i, 6);
        check("mid_busy_pre", int'(busy), 1);
        check("mid_wren_pre", int'(mem_wren), 1);
        resetn = 1'b0;
        @(negedge clock);
        check("mid_wren", int'(mem_wren), 0);
        check("mid_busy", int'(busy), 0);
        check("mid_drop", int'(dropped_count), 0);
        resetn = 1'b1;
        mem_ready = 1'b1;
        clear_q();
        repeat (15) @(negedge clock);
        check("mid_no_writes", wq_addr.size(), 0);
        check("mid_busy_post", int'(busy), 0);
        check("mid_in_ready", int'(in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
